pfpu_lzc_norm: RTL and testbench

- Parametrised, pipelined leading-zero/leading-one counter and normaliser for the PFPU integer-to-float and renormalisation paths.
- Each pipeline stage resolves one bit of the count by binary search on the upper half of the remaining window and left-shifts the operand accordingly.
- Output: the count, a zero flag and the normalised operand, with valid tracking and a global pipeline enable.

---
 rtl/pfpu_lzc_norm.sv | 100 ++++++++++
 tb/tb_pfpu_lzc_norm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pfpu_lzc_norm.sv
// Pipelined leading-zero / leading-one counter and normaliser.
// One pipeline stage per count bit: stage k tests the upper (WIDTH >> k) bits
// of the test word and, if they are all zero, sets count bit (LOG-k) and
// left-shifts both the test word and the data word by that amount.
// The last stage also resolves the "no terminating bit" case and drives the
// registered outputs directly, so latency is exactly LOG enabled cycles.
module pfpu_lzc_norm #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG   = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             ce,
  input  logic             valid_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             valid_o,
  output logic [LOG:0]     cnt_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] norm_o
);

  if (LOG != $clog2(WIDTH) || WIDTH < 4 || WIDTH > 64 ||
      (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_param
    $error("pfpu_lzc_norm: WIDTH must be a power of two in 4..64 and LOG must equal clog2(WIDTH)");
  end

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [LOG:0]     cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(WIDTH);

  // Inter-stage registers for stages 1..LOG-1 (stage LOG is the output register)
  word_t          t_q [LOG-1];
  word_t          s_q [LOG-1];
  cnt_t           c_q [LOG-1];
  logic [LOG-2:0] v_q;

  // Per-stage inputs and shifted results
  word_t          t_in [LOG];
  word_t          s_in [LOG];
  cnt_t           c_in [LOG];
  logic [LOG-1:0] v_in;
  word_t          t_nx [LOG];
  word_t          s_nx [LOG];
  cnt_t           c_nx [LOG];

  logic           final_zero;

  // Input conditioning plus the per-stage binary-search shift step
  always_comb begin
    t_in[0] = mode_i ? ~d_i : d_i;
    s_in[0] = d_i;
    c_in[0] = '0;
    v_in[0] = valid_i;
    for (int unsigned j = 1; j < LOG; j++) begin
      t_in[j] = t_q[j-1];
      s_in[j] = s_q[j-1];
      c_in[j] = c_q[j-1];
      v_in[j] = v_q[j-1];
    end
    for (int unsigned j = 0; j < LOG; j++) begin
      if ((t_in[j] >> (WIDTH - (WIDTH >> (j + 1)))) == '0) begin
        t_nx[j] = t_in[j] << (WIDTH >> (j + 1));
        s_nx[j] = s_in[j] << (WIDTH >> (j + 1));
        c_nx[j] = c_in[j] | (cnt_t'(1) << (LOG - 1 - j));
      end else begin
        t_nx[j] = t_in[j];
        s_nx[j] = s_in[j];
        c_nx[j] = c_in[j];
      end
    end
  end

  // After the final shift a clear MSB means the whole test word was zero
  assign final_zero = ~t_nx[LOG-1][WIDTH-1];

  // Pipeline advance on enable; reset clears valid tracking and outputs only
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      v_q     <= '0;
      valid_o <= 1'b0;
      cnt_o   <= '0;
      zero_o  <= 1'b0;
      norm_o  <= '0;
    end else if (ce) begin
      for (int unsigned j = 0; j < LOG - 1; j++) begin
        t_q[j] <= t_nx[j];
        s_q[j] <= s_nx[j];
        c_q[j] <= c_nx[j];
      end
      v_q     <= v_in[LOG-2:0];
      valid_o <= v_in[LOG-1];
      zero_o  <= final_zero;
      cnt_o   <= final_zero ? CNT_FULL : c_nx[LOG-1];
      norm_o  <= final_zero ? '0 : s_nx[LOG-1];
    end
  end

endmodule

// File: tb/tb_pfpu_lzc_norm.sv
// Bench for pfpu_lzc_norm at WIDTH 32, 8 and 64 sharing control inputs.
// Expected results are queued when an operand is sampled and popped when the
// matching DUT raises valid_o on an enabled edge.
module tb_pfpu_lzc_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        vin = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] d32 = '0;
  logic [7:0]  d8 = '0;
  logic [63:0] d64 = '0;

  logic        v32, v8, v64;
  logic [5:0]  c32;
  logic [3:0]  c8;
  logic [6:0]  c64;
  logic        z32, z8, z64;
  logic [31:0] n32;
  logic [7:0]  n8;
  logic [63:0] n64;

  always #5 clk = ~clk;

  pfpu_lzc_norm #(.WIDTH(32), .LOG(5)) u32 (
    .sys_clk(clk), .sys_rst(rst), .ce(ce), .valid_i(vin), .mode_i(mode), .d_i(d32),
    .valid_o(v32), .cnt_o(c32), .zero_o(z32), .norm_o(n32));
  pfpu_lzc_norm #(.WIDTH(8), .LOG(3)) u8 (
    .sys_clk(clk), .sys_rst(rst), .ce(ce), .valid_i(vin), .mode_i(mode), .d_i(d8),
    .valid_o(v8), .cnt_o(c8), .zero_o(z8), .norm_o(n8));
  pfpu_lzc_norm #(.WIDTH(64), .LOG(6)) u64 (
    .sys_clk(clk), .sys_rst(rst), .ce(ce), .valid_i(vin), .mode_i(mode), .d_i(d64),
    .valid_o(v64), .cnt_o(c64), .zero_o(z64), .norm_o(n64));

  typedef struct {
    logic [6:0]  cnt;
    logic        zero;
    logic [63:0] norm;
    int          tag;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic        m;
    logic [6:0]  cnt;
    logic        zero;
    logic [31:0] norm;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;

  // Reference: scan from the MSB while bits equal the mode bit
  function automatic exp_t model(input logic [63:0] d, input logic m, input int w);
    exp_t        e;
    int          n;
    logic [63:0] mask;
    n = 0;
    while (n < w && d[w-1-n] == m) n++;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    e.cnt  = 7'(n);
    e.zero = (n == w);
    e.norm = e.zero ? 64'd0 : ((d << n) & mask);
    e.tag  = 0;
    return e;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  function automatic void cmpres(input string nm, input logic [6:0] c, input logic z,
                                 input logic [63:0] n, input exp_t e, input int lat);
    chk({nm, "_cnt"}, {57'd0, c}, {57'd0, e.cnt});
    chk({nm, "_zero"}, {63'd0, z}, {63'd0, e.zero});
    chk({nm, "_norm"}, n, e.norm);
    chk({nm, "_latency"}, 64'(en_cnt - e.tag), 64'(lat));
  endfunction

  // Monitor: sample #1 after each rising edge
  logic        ce_s, rst_s;
  logic        hv;
  logic [5:0]  hc;
  logic        hz;
  logic [31:0] hn;
  always @(posedge clk) begin
    exp_t e;
    ce_s  = ce;
    rst_s = rst;
    #1;
    if (rst_s) begin
      q32.delete();
      q8.delete();
      q64.delete();
      chk("rst_valid32", {63'd0, v32}, 64'd0);
      chk("rst_cnt32", {58'd0, c32}, 64'd0);
      chk("rst_zero32", {63'd0, z32}, 64'd0);
      chk("rst_norm32", {32'd0, n32}, 64'd0);
      chk("rst_valid8", {63'd0, v8}, 64'd0);
      chk("rst_valid64", {63'd0, v64}, 64'd0);
    end else if (ce_s) begin
      en_cnt++;
      if (v32) begin
        if (q32.size() == 0) chk("spurious32_valid", {63'd0, v32}, 64'd0);
        else begin e = q32.pop_front(); cmpres("r32", {1'b0, c32}, z32, {32'd0, n32}, e, 5); end
      end
      if (v8) begin
        if (q8.size() == 0) chk("spurious8_valid", {63'd0, v8}, 64'd0);
        else begin e = q8.pop_front(); cmpres("r8", {3'd0, c8}, z8, {56'd0, n8}, e, 3); end
      end
      if (v64) begin
        if (q64.size() == 0) chk("spurious64_valid", {63'd0, v64}, 64'd0);
        else begin e = q64.pop_front(); cmpres("r64", c64, z64, n64, e, 6); end
      end
    end else begin
      chk("hold_valid32", {63'd0, v32}, {63'd0, hv});
      chk("hold_cnt32", {58'd0, c32}, {58'd0, hc});
      chk("hold_zero32", {63'd0, z32}, {63'd0, hz});
      chk("hold_norm32", {32'd0, n32}, {32'd0, hn});
    end
    hv = v32;
    hc = c32;
    hz = z32;
    hn = n32;
  end

  // Drive one cycle of stimulus on the falling edge and queue expectations
  task automatic drive(input logic r, input logic c, input logic v, input logic m,
                       input logic [31:0] a, input logic [7:0] b, input logic [63:0] f,
                       input exp_t x32, input logic have_x);
    exp_t e;
    @(negedge clk);
    rst  = r;
    ce   = c;
    vin  = v;
    mode = m;
    d32  = a;
    d8   = b;
    d64  = f;
    if (c && v && !r) begin
      e = have_x ? x32 : model({32'd0, a}, m, 32);
      e.tag = en_cnt;
      q32.push_back(e);
      e = model({56'd0, b}, m, 8);
      e.tag = en_cnt;
      q8.push_back(e);
      e = model(f, m, 64);
      e.tag = en_cnt;
      q64.push_back(e);
    end
  endtask

  task automatic idle(input logic r, input logic c, input int n);
    exp_t x;
    x = '{default: '0};
    for (int i = 0; i < n; i++) drive(r, c, 1'b0, 1'b0, 32'd0, 8'd0, 64'd0, x, 1'b0);
  endtask

  vec_t tbl[12];

  initial begin
    exp_t        x;
    int          ops;
    logic        c, v, m;
    logic [31:0] a;
    logic [7:0]  b;
    logic [63:0] f;

    tbl[0]  = '{32'h00000000, 1'b0, 7'd32, 1'b1, 32'h00000000};
    tbl[1]  = '{32'hFFFFFFFF, 1'b0, 7'd0,  1'b0, 32'hFFFFFFFF};
    tbl[2]  = '{32'h00012345, 1'b0, 7'd15, 1'b0, 32'h91A28000};
    tbl[3]  = '{32'hFFFF0F00, 1'b1, 7'd16, 1'b0, 32'h0F000000};
    tbl[4]  = '{32'hFFFFFFFF, 1'b1, 7'd32, 1'b1, 32'h00000000};
    tbl[5]  = '{32'h00000000, 1'b1, 7'd0,  1'b0, 32'h00000000};
    tbl[6]  = '{32'h80000000, 1'b0, 7'd0,  1'b0, 32'h80000000};
    tbl[7]  = '{32'hFFFFFFFE, 1'b1, 7'd31, 1'b0, 32'h00000000};
    tbl[8]  = '{32'h00000001, 1'b0, 7'd31, 1'b0, 32'h80000000};
    tbl[9]  = '{32'h7FFFFFFF, 1'b1, 7'd0,  1'b0, 32'h7FFFFFFF};
    tbl[10] = '{32'h0F0F0F0F, 1'b0, 7'd4,  1'b0, 32'hF0F0F0F0};
    tbl[11] = '{32'hC0000000, 1'b1, 7'd2,  1'b0, 32'h00000000};

    idle(1'b1, 1'b0, 3);

    // Directed table, modes alternate between entries
    foreach (tbl[i]) begin
      x.cnt  = tbl[i].cnt;
      x.zero = tbl[i].zero;
      x.norm = {32'd0, tbl[i].norm};
      x.tag  = 0;
      drive(1'b0, 1'b1, 1'b1, tbl[i].m, tbl[i].d, 8'($urandom), {$urandom, $urandom}, x, 1'b1);
    end
    idle(1'b0, 1'b1, 8);

    // Single-bit sweep, back to back
    for (int i = 0; i < 32; i++) begin
      x.cnt  = 7'(31 - i);
      x.zero = 1'b0;
      x.norm = 64'h80000000;
      x.tag  = 0;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd1 << i, (i == 31) ? 8'd0 : 8'd1 << (i % 8),
            64'd1 << (2 * i + (i % 2)), x, 1'b1);
    end
    idle(1'b0, 1'b1, 8);

    // Reset mid-stream with ce=1 and a valid operand on the reset edge
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b1, 1'b1, 1'(i % 2), $urandom, 8'($urandom), {$urandom, $urandom}, x, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 8'h1, 64'h1, x, 1'b0);
    idle(1'b0, 1'b1, 8);

    // Reset while stalled
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 1'b1, 1'b0, $urandom, 8'($urandom), {$urandom, $urandom}, x, 1'b0);
    idle(1'b0, 1'b0, 2);
    idle(1'b1, 1'b0, 1);
    idle(1'b0, 1'b1, 8);

    // Random enable / valid / mode with biased leading runs
    ops = 0;
    for (int k = 0; k < 20000 && ops < 4000; k++) begin
      c = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      a = $urandom >> $urandom_range(0, 32);
      b = 8'($urandom) >> $urandom_range(0, 8);
      f = {$urandom, $urandom} >> $urandom_range(0, 64);
      if (m) begin
        a = ~a;
        b = ~b;
        f = ~f;
      end
      if (c && v) ops++;
      drive(1'b0, c, v, m, a, b, f, x, 1'b0);
    end
    idle(1'b0, 1'b1, 10);

    chk("drain32_pending", 64'(q32.size()), 64'd0);
    chk("drain8_pending", 64'(q8.size()), 64'd0);
    chk("drain64_pending", 64'(q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
